// File: rtl/bist_pkg.sv
// Shared definitions between the BIST host sequencer and the BIST engine:
// sequencer state encoding and the per-iteration result encoding on `mode`.
package bist_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_RUN       = 3'd2;
  localparam logic [2:0] ST_WAIT_INIT = 3'd3;
  localparam logic [2:0] ST_GAP       = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_RUN       = ST_RUN,
    S_WAIT_INIT = ST_WAIT_INIT,
    S_GAP       = ST_GAP,
    S_DONE      = ST_DONE
  } state_e;

  localparam logic MODE_PASS = 1'b1;
  localparam logic MODE_FAIL = 1'b0;

endpackage

// File: rtl/bist_timeout_timer.sv
// Loadable down-counter shared by the phase timeouts and the inter-iteration gap.
// `expired` is high while the count sits at zero; load takes priority over counting.
module bist_timeout_timer #(
  parameter int TO_W = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            load,
  input  logic            enable,
  input  logic [TO_W-1:0] load_val,
  output logic            expired
);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/bist_sequencer.sv
// Host-side BIST controller: runs a programmable number of engine iterations,
// supervises each phase with a timeout and reports an aggregate result.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter int RUN_W      = 8,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req,
  input  logic [RUN_W-1:0] runs,
  input  logic             abort,
  input  logic             init,
  input  logic             running,
  input  logic             bist_end,
  input  logic             mode,
  input  logic             finish,
  output logic             bist_start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [RUN_W-1:0] fail_cnt,
  output logic             timeout
);

  localparam logic [TO_W-1:0] TO_LOAD  = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] GAP_LOAD = TO_W'(GAP_CYCLES - 1);

  state_e           state_q;
  logic [RUN_W-1:0] remaining_q;
  logic [RUN_W-1:0] fail_cnt_q;
  logic [RUN_W-1:0] fail_cnt_d;
  logic             bist_start_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             timeout_q;

  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_expired;
  logic [TO_W-1:0]  tmr_val;

  logic             unused_finish;
  assign unused_finish = finish;

  assign fail_cnt_d = (fail_cnt_q == '1) ? fail_cnt_q : fail_cnt_q + 1'b1;

  // Reload on every state change so each waiting state starts a full window;
  // IDLE keeps the timeout value preloaded for the START entry.
  always_comb begin
    tmr_load = 1'b1;
    tmr_val  = TO_LOAD;
    unique case (state_q)
      S_START:     tmr_load = running;
      S_RUN:       tmr_load = bist_end;
      S_WAIT_INIT: begin
        tmr_load = init;
        tmr_val  = GAP_LOAD;
      end
      S_GAP:       tmr_load = tmr_expired;
      default:     tmr_load = 1'b1;
    endcase
  end

  assign tmr_en = (state_q == S_START) || (state_q == S_RUN) ||
                  (state_q == S_WAIT_INIT) || (state_q == S_GAP);

  bist_timeout_timer #(
    .TO_W(TO_W)
  ) u_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .enable   (tmr_en),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      fail_cnt_q   <= '0;
      bist_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Abort outranks every event in the active states, including bist_end.
      if (abort && tmr_en) begin
        bist_start_q <= 1'b0;
        busy_q       <= 1'b0;
        done_q       <= 1'b1;
        pass_q       <= 1'b0;
        state_q      <= S_DONE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (req) begin
              remaining_q  <= (runs == '0) ? RUN_W'(1) : runs;
              fail_cnt_q   <= '0;
              pass_q       <= 1'b0;
              timeout_q    <= 1'b0;
              bist_start_q <= 1'b1;
              busy_q       <= 1'b1;
              state_q      <= S_START;
            end
          end
          S_START: begin
            if (running) begin
              state_q <= S_RUN;
            end else if (tmr_expired) begin
              timeout_q    <= 1'b1;
              bist_start_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= 1'b0;
              state_q      <= S_DONE;
            end
          end
          S_RUN: begin
            if (bist_end) begin
              if (mode == MODE_FAIL) begin
                fail_cnt_q <= fail_cnt_d;
              end
              remaining_q  <= remaining_q - 1'b1;
              bist_start_q <= 1'b0;
              state_q      <= S_WAIT_INIT;
            end else if (tmr_expired) begin
              timeout_q    <= 1'b1;
              bist_start_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              pass_q       <= 1'b0;
              state_q      <= S_DONE;
            end
          end
          S_WAIT_INIT: begin
            if (init) begin
              if (remaining_q != '0) begin
                state_q <= S_GAP;
              end else begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                pass_q  <= (fail_cnt_q == '0);
                state_q <= S_DONE;
              end
            end else if (tmr_expired) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              pass_q    <= 1'b0;
              state_q   <= S_DONE;
            end
          end
          S_GAP: begin
            if (tmr_expired) begin
              bist_start_q <= 1'b1;
              state_q      <= S_START;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign bist_start = bist_start_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_cnt   = fail_cnt_q;
  assign timeout    = timeout_q;

endmodule
